float_normalizer: RTL
=====================

// Module: float_normalizer
// PURPOSE
//  Post-accumulate stage downstream of the float accumulator. Takes a raw
//  sign/exponent/mantissa result (carry and leading zeros allowed) and
//  returns a packed normalized float word. The sequential FSM shifts one bit
//  per cycle. Valid/ready on both sides.
// PARAMETERS
//  WIDTH  32  packed output width; sign at [WIDTH-1]
//  EXP_W   8  exponent field width, at [WIDTH-2:MAN_W]
//  MAN_W  23  fraction field width, at [MAN_W-1:0]; hidden bit implicit
// PORTS
//  Clk        in   1        clock, all state on posedge
//  Rst        in   1        synchronous, active-high reset
//  in_valid   in   1        raw result present
//  in_ready   out  1        = (state==IDLE); transfer on in_valid&&in_ready
//  in_sign    in   1        raw sign
//  in_exp     in   EXP_W    raw biased exponent
//  in_man     in   MAN_W+2  [MAN_W+1]=carry, [MAN_W]=hidden, below=fraction
//  out_valid  out  1        packed result valid
//  out_ready  in   1        consumer accepts; transfer on out_valid&&out_ready
//  out_data   out  WIDTH    {sign, exp, fraction}
//  out_flags  out  3        {overflow, underflow, zero}
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, out_data=0, out_flags=0, internal regs=0.
//   in_ready=1 from the first cycle after Rst drops.
//   Rst mid-operation aborts the operation and discards it. No output is produced.
//  States: IDLE, CHECK, SHIFT, PACK, HOLD.
//  IDLE: capture sign/exp/man on transfer -> CHECK.
//  CHECK: man==0 -> zero result, PACK.
//   man[MAN_W+1]=1 -> man>>=1, exp+=1, keep the shifted-out bit as rbit -> PACK.
//   man[MAN_W]=1 -> PACK. Otherwise -> SHIFT.
//  SHIFT: each cycle man<<=1, exp-=1. Go to PACK when the shifted man[MAN_W]=1.
//   If exp would go below 1: underflow; result=+0, flags underflow|zero -> PACK.
//  PACK: if exp>=2^EXP_W-1, overflow: out_data={sign,all-ones exp,0}.
//   Else out_data={sign,exp,man[MAN_W-1:0]}. Register out_data and out_flags.
//   Set out_valid -> HOLD.
//  HOLD: out_valid, out_data and out_flags hold while out_ready=0.
//   On transfer: out_valid=0 at the next edge -> IDLE. No overlap, one op in flight.
//  Zero result is always +0 (sign dropped), flags=001.
//  Latency: transfer at edge N gives out_valid high after edge N+2+k.
//   k = number of left shifts, 0..MAN_W.
//  Exponent arithmetic is done at EXP_W+1 bits to detect wrap.
//   in_exp==0 with non-zero man is treated as underflow.
// CONFIGURATION
//  FLOAT_NORM_ROUND_EN defined: the right-shift path rounds to nearest even.
//   If rbit=1 and man[0]=1, man+=1. If that carries into [MAN_W+1], renormalize:
//   man>>=1, exp+=1 and re-check overflow. Costs one extra PACK cycle only
//   when the increment occurs.
//  Undefined: the shifted-out bit is discarded (truncate). Latency is fixed
//   as above.
// TESTING (WIDTH=32, EXP_W=8, MAN_W=23)
//  1. exp=0x80, man=0x0800000, sign=0 -> out_data=0x40000000, flags=000.
//     out_valid after 2 edges. Hold out_ready=0 for 3 cycles: data stable,
//     in_ready=0.
//  2. exp=0x7F, man=0x1800000 (carry) -> out_data=0x40400000, latency 2.
//  3. exp=0x80, man=0x0200000 -> 2 shifts, out_data=0x3F000000, latency 4.
//  4. man=0, sign=1 -> out_data=0x00000000, flags=001.
//     exp=0x02, man=0x0000001 -> underflow: out_data=0, flags=011.
//  5. exp=0xFE, man=0x1000000 -> out_data=0x7F800000, flags=100.
//     Assert Rst during SHIFT: out_valid stays 0, in_ready=1 next cycle.
//  6. exp=0x7F, man=0x1800003 -> with FLOAT_NORM_ROUND_EN: 0x40400002.
//     Without it: 0x40400001.

Source files
------------

// File: rtl/float_normalizer.sv
// float_normalizer: normalizes a raw {sign, exponent, mantissa} result from
// the float accumulator into a packed float word. It shifts one bit per cycle
// and holds one operation at a time, with valid/ready handshakes on both sides.
// Optional build macro FLOAT_NORM_ROUND_EN: round-to-nearest-even on the
// carry right-shift path. When the macro is undefined, the shifted-out bit
// is dropped.
//
// state | meaning
// IDLE  | ready for a new raw result
// CHECK | classify: zero, carry, already normalized, or needs left shift
// SHIFT | shift left one bit per cycle until the hidden bit is set
// PACK  | build the packed word and the flags (extra cycle when rounding bumps)
// HOLD  | present the result until the consumer takes it
module float_normalizer #(
    parameter int WIDTH = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic [MAN_W+1:0]   in_man,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_flags
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] PACK  = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    // The exponent is carried with one extra bit so that carry and overflow
    // remain visible. It is never decremented below 1, so it cannot wrap low.
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    logic [2:0]       state;
    logic             sign_r;
    logic [EXP_W:0]   exp_r;
    logic [MAN_W+1:0] man_r;
    logic             zero_r;
    logic             unf_r;
`ifdef FLOAT_NORM_ROUND_EN
    logic             rbit_r;
`endif

    logic [EXP_W:0]   exp_n;
    logic [MAN_W-1:0] frac_n;

    assign in_ready = (state == IDLE);

    // A mantissa can reach PACK with its carry bit set only after a rounding
    // increment. Renormalize that case here so no further cycle is needed.
    always_comb begin
        exp_n  = exp_r;
        frac_n = man_r[MAN_W-1:0];
        if (man_r[MAN_W+1]) begin
            exp_n  = exp_r + EXP_ONE;
            frac_n = man_r[MAN_W:1];
        end
    end

    // Normalizer FSM and the registered output stage
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            man_r     <= '0;
            zero_r    <= 1'b0;
            unf_r     <= 1'b0;
`ifdef FLOAT_NORM_ROUND_EN
            rbit_r    <= 1'b0;
`endif
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= in_sign;
                        exp_r  <= {1'b0, in_exp};
                        man_r  <= in_man;
                        zero_r <= 1'b0;
                        unf_r  <= 1'b0;
`ifdef FLOAT_NORM_ROUND_EN
                        rbit_r <= 1'b0;
`endif
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (man_r == '0) begin
                        zero_r <= 1'b1;
                        state  <= PACK;
                    end else if (exp_r == '0) begin
                        // A zero exponent with a non-zero mantissa has no
                        // normal representation.
                        zero_r <= 1'b1;
                        unf_r  <= 1'b1;
                        state  <= PACK;
                    end else if (man_r[MAN_W+1]) begin
                        man_r  <= man_r >> 1;
                        exp_r  <= exp_r + EXP_ONE;
`ifdef FLOAT_NORM_ROUND_EN
                        rbit_r <= man_r[0];
`endif
                        state  <= PACK;
                    end else if (man_r[MAN_W]) begin
                        state  <= PACK;
                    end else begin
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (exp_r <= EXP_ONE) begin
                        zero_r <= 1'b1;
                        unf_r  <= 1'b1;
                        state  <= PACK;
                    end else begin
                        man_r <= man_r << 1;
                        exp_r <= exp_r - EXP_ONE;
                        if (man_r[MAN_W-1])
                            state <= PACK;
                    end
                end
                PACK: begin
`ifdef FLOAT_NORM_ROUND_EN
                    if (rbit_r && man_r[0] && !zero_r) begin
                        man_r  <= man_r + {{(MAN_W+1){1'b0}}, 1'b1};
                        rbit_r <= 1'b0;
                    end else
`endif
                    begin
                        if (zero_r) begin
                            out_data  <= '0;
                            out_flags <= {1'b0, unf_r, 1'b1};
                        end else if (exp_n >= EXP_MAX) begin
                            out_data  <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            out_flags <= 3'b100;
                        end else begin
                            out_data  <= {sign_r, exp_n[EXP_W-1:0], frac_n};
                            out_flags <= 3'b000;
                        end
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
